// File: rtl/hack_core.sv
// hack_core: multi-cycle Hack CPU sharing one req/ack memory port for fetch and data.
// Define HACK_CORE_PERF_EN to build the cycle and retire performance counters.
module hack_core #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int PC_STEP = 2
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              halt_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] rega_o,
  output logic [DATA_W-1:0] regd_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [2:0]        state_o,
  output logic [31:0]       cycle_cnt_o,
  output logic [31:0]       retire_cnt_o
);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_READ   = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] rega, regd, ir, mreg, wdata;
  logic [ADDR_W-1:0] pc, waddr, pc_inc;
  logic [DATA_W-1:0] alu_x, alu_y, alu_out;
  logic              zr, ng, jump, retire;
  logic              unused_ir;

  assign pc_inc    = pc + ADDR_W'(PC_STEP);
  assign unused_ir = ^ir;

  always_comb begin
    alu_x = regd;
    alu_y = ir[12] ? mreg : rega;
    if (ir[11]) alu_x = '0;
    if (ir[10]) alu_x = ~alu_x;
    if (ir[9])  alu_y = '0;
    if (ir[8])  alu_y = ~alu_y;
    alu_out = ir[7] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (ir[6])  alu_out = ~alu_out;
  end

  assign zr   = (alu_out == '0);
  assign ng   = alu_out[DATA_W-1];
  assign jump = (ir[2] & ng) | (ir[1] & zr) | (ir[0] & ~ng & ~zr);

  // Every retiring path funnels through one place so halt_i is only honoured there.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_HALT:   if (!halt_i) state_next = S_FETCH;
      S_FETCH:  if (mem_ack_i) state_next = S_DECODE;
      S_DECODE: begin
        if (!ir[15]) retire = 1'b1;
        else         state_next = ir[12] ? S_READ : S_EXEC;
      end
      S_READ:   if (mem_ack_i) state_next = S_EXEC;
      S_EXEC: begin
        if (ir[3]) state_next = S_WRITE;
        else       retire = 1'b1;
      end
      S_WRITE:  if (mem_ack_i) retire = 1'b1;
      default:  state_next = S_HALT;
    endcase
    if (retire) state_next = halt_i ? S_HALT : S_FETCH;
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state)
      S_FETCH: begin
        mem_req_o  = 1'b1;
        mem_addr_o = pc;
      end
      S_READ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = rega[ADDR_W-1:0];
      end
      S_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = waddr;
        mem_wdata_o = wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state <= S_HALT;
      rega  <= '0;
      regd  <= '0;
      pc    <= '0;
      ir    <= '0;
      mreg  <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_FETCH: if (mem_ack_i) ir <= mem_rdata_i;
        S_DECODE: begin
          if (!ir[15]) begin
            rega <= {{(DATA_W-15){1'b0}}, ir[14:0]};
            pc   <= pc_inc;
          end
        end
        S_READ: if (mem_ack_i) mreg <= mem_rdata_i;
        S_EXEC: begin
          // Write address and jump target both use A as it was before this instruction.
          if (ir[5]) rega <= alu_out;
          if (ir[4]) regd <= alu_out;
          if (ir[3]) begin
            waddr <= rega[ADDR_W-1:0];
            wdata <= alu_out;
          end
          pc <= jump ? rega[ADDR_W-1:0] : pc_inc;
        end
        default: ;
      endcase
    end
  end

  assign rega_o  = rega;
  assign regd_o  = regd;
  assign pc_o    = pc;
  assign state_o = state;

`ifdef HACK_CORE_PERF_EN
  logic [31:0] cycle_cnt, retire_cnt;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)          retire_cnt <= retire_cnt + 32'd1;
    end
  end

  assign cycle_cnt_o  = cycle_cnt;
  assign retire_cnt_o = retire_cnt;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign cycle_cnt_o   = '0;
  assign retire_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_hack_core.sv
// Scoreboard bench for hack_core: an instruction-level model predicts every memory
// transaction and the architectural state at each halt; a monitor doubles as the memory.
module tb_hack_core;

  logic        clk = 1'b0;
  logic        resetb, halt_i;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [15:0] rega_o, regd_o, pc_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt_o, retire_cnt_o;

  always #5 clk = ~clk;

  hack_core #(.DATA_W(16), .ADDR_W(16), .PC_STEP(2)) dut (
    .clk(clk), .resetb(resetb), .halt_i(halt_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .rega_o(rega_o), .regd_o(regd_o), .pc_o(pc_o), .state_o(state_o),
    .cycle_cnt_o(cycle_cnt_o), .retire_cnt_o(retire_cnt_o)
  );

  typedef enum int {K_FETCH, K_READ, K_WRITE} kind_t;
  typedef struct { kind_t kind; logic [15:0] addr; logic [15:0] data; int lat; } txn_t;
  typedef struct { logic [15:0] a; logic [15:0] d; logic [15:0] pc; } arch_t;

  txn_t        exp_q[$];
  arch_t       snaps[$];
  logic [15:0] mem  [0:65535];
  logic [15:0] mmem [0:65535];

  int checks = 0, errors = 0;
  int fetches_done = 0, cyc = 0, last_fetch_cyc = 0;
  int max_wait = 0, stall = 0, check_lat = 0, wait_left = 0, pending = 0;
  logic        held_we;
  logic [15:0] held_addr, held_wdata;
  txn_t        mon_e;
  logic [15:0] m_a, m_d, m_pc;
  int          m_prev_lat, m_total_lat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] hack_alu(logic [15:0] x, logic [15:0] y, logic [5:0] c);
    logic [15:0] r;
    if (c[5]) x = 16'h0;
    if (c[4]) x = 16'hFFFF - x;
    if (c[3]) y = 16'h0;
    if (c[2]) y = 16'hFFFF - y;
    r = c[1] ? 16'(x + y) : (x & y);
    if (c[0]) r = 16'hFFFF - r;
    return r;
  endfunction

  // Runs n instructions of the architectural model, queueing the transactions they imply.
  task automatic model_run(input int n);
    logic [15:0] ins, y, res, old_a;
    int lat;
    bit jmp;
    for (int i = 0; i < n; i++) begin
      ins = mmem[m_pc];
      exp_q.push_back('{K_FETCH, m_pc, 16'h0, m_prev_lat});
      if (ins[15] == 1'b0) begin
        m_a  = {1'b0, ins[14:0]};
        m_pc = 16'(m_pc + 16'd2);
        lat  = 2;
      end else begin
        old_a = m_a;
        lat   = 3;
        y     = m_a;
        if (ins[12]) begin
          exp_q.push_back('{K_READ, m_a, 16'h0, 0});
          y = mmem[m_a];
          lat++;
        end
        res = hack_alu(m_d, y, ins[11:6]);
        if ($signed(res) < 0)    jmp = ins[2];
        else if (res == 16'h0)   jmp = ins[1];
        else                     jmp = ins[0];
        if (ins[5]) m_a = res;
        if (ins[4]) m_d = res;
        if (ins[3]) begin
          exp_q.push_back('{K_WRITE, old_a, res, 0});
          mmem[old_a] = res;
          lat++;
        end
        m_pc = jmp ? old_a : 16'(m_pc + 16'd2);
      end
      m_prev_lat  = lat;
      m_total_lat += lat;
      snaps.push_back('{m_a, m_d, m_pc});
    end
  endtask

  task automatic check_arch(input string tag);
    int k;
    k = fetches_done;
    if (k >= snaps.size()) begin
      checkOutput({tag, "_retired"}, 32'(k), 32'(snaps.size() - 1));
      return;
    end
    checkOutput({tag, "_A"},  32'(rega_o), 32'(snaps[k].a));
    checkOutput({tag, "_D"},  32'(regd_o), 32'(snaps[k].d));
    checkOutput({tag, "_PC"}, 32'(pc_o),   32'(snaps[k].pc));
  endtask

  // Memory responder and scoreboard monitor.
  always @(negedge clk) begin
    if (!resetb) begin
      pending        = 0;
      fetches_done   = 0;
      last_fetch_cyc = 0;
      mem_ack_i      = 1'b0;
      mem_rdata_i    = 16'h0;
    end else begin
      checkOutput("req_vs_state", 32'(mem_req_o), 32'(state_o inside {3'd1, 3'd3, 3'd5}));
      checkOutput("we_vs_state",  32'(mem_we_o),  32'(state_o == 3'd5));
      if (!mem_req_o) begin
        pending     = 0;
        mem_ack_i   = 1'($urandom_range(0, 1));
        mem_rdata_i = 16'($urandom);
      end else begin
        if (pending == 0) begin
          pending    = 1;
          wait_left  = $urandom_range(0, max_wait);
          held_we    = mem_we_o;
          held_addr  = mem_addr_o;
          held_wdata = mem_wdata_o;
        end else begin
          checkOutput("hold_we",    32'(mem_we_o),    32'(held_we));
          checkOutput("hold_addr",  32'(mem_addr_o),  32'(held_addr));
          checkOutput("hold_wdata", 32'(mem_wdata_o), 32'(held_wdata));
        end
        if (stall == 0 && wait_left == 0) begin
          mem_ack_i = 1'b1;
          pending   = 0;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            mem_rdata_i     = 16'($urandom);
          end else begin
            mem_rdata_i = mem[mem_addr_o];
          end
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_txn: got addr 0x%0h we %0b, expected no transaction",
                     mem_addr_o, mem_we_o);
          end else begin
            mon_e = exp_q.pop_front();
            checkOutput("txn_we",   32'(mem_we_o),   32'(mon_e.kind == K_WRITE));
            checkOutput("txn_addr", 32'(mem_addr_o), 32'(mon_e.addr));
            if (mon_e.kind == K_WRITE)
              checkOutput("txn_wdata", 32'(mem_wdata_o), 32'(mon_e.data));
            if (mon_e.kind == K_FETCH) begin
              if (check_lat != 0 && mon_e.lat > 0)
                checkOutput("fetch_latency", 32'(cyc - last_fetch_cyc), 32'(mon_e.lat));
              last_fetch_cyc = cyc;
              fetches_done++;
            end
          end
        end else begin
          mem_ack_i   = 1'b0;
          mem_rdata_i = 16'($urandom);
          if (wait_left > 0) wait_left--;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Lets the DUT run until n instructions are fetched, then halts it and checks state.
  task automatic applyStimulus(input int n, input bit rand_halt);
    int          budget;
    bit          was_halt;
    logic [31:0] prev_cyc;
    was_halt = 0;
    prev_cyc = '0;
    budget   = 0;
    while (fetches_done < n && budget < 30000) begin
      @(posedge clk); #1;
      budget++;
      if (state_o == 3'd0) begin
        check_arch("halt");
`ifdef HACK_CORE_PERF_EN
        checkOutput("halt_retire_cnt", retire_cnt_o, 32'(fetches_done));
        if (was_halt) checkOutput("halt_cycle_cnt_frozen", cycle_cnt_o, prev_cyc);
`else
        checkOutput("cycle_cnt_off", cycle_cnt_o, 32'h0);
        checkOutput("retire_cnt_off", retire_cnt_o, 32'h0);
`endif
        was_halt = 1;
        prev_cyc = cycle_cnt_o;
      end else begin
        was_halt = 0;
      end
      halt_i = rand_halt && ($urandom_range(0, 7) == 0);
    end
    if (fetches_done < n) checkOutput("fetch_timeout", 32'(fetches_done), 32'(n));
    halt_i = 1'b1;
    budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (state_o != 3'd0 && budget < 500);
    checkOutput("end_halt_state", 32'(state_o), 32'h0);
    checkOutput("end_halt_req", 32'(mem_req_o), 32'h0);
    check_arch("end");
    checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
`ifdef HACK_CORE_PERF_EN
    checkOutput("end_retire_cnt", retire_cnt_o, 32'(n));
    if (check_lat != 0) checkOutput("end_cycle_cnt", cycle_cnt_o, 32'(m_total_lat));
`else
    checkOutput("end_cycle_cnt_off", cycle_cnt_o, 32'h0);
`endif
  endtask

  task automatic model_reset();
    exp_q.delete();
    snaps.delete();
    m_a = 16'h0; m_d = 16'h0; m_pc = 16'h0;
    m_prev_lat = 0; m_total_lat = 0;
    snaps.push_back('{16'h0, 16'h0, 16'h0});
  endtask

  initial begin
    resetb    = 1'b0;
    halt_i    = 1'b0;
    max_wait  = 0;
    check_lat = 1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
    mem[16'h0000] = 16'h1234;
    mem[16'h0002] = 16'h0010;
    mem[16'h0004] = 16'hFDD0;
    mem[16'h0006] = 16'h0020;
    mem[16'h0008] = 16'hE308;
    mem[16'h000A] = 16'h0040;
    mem[16'h000C] = 16'hEA87;
    mem[16'h0040] = 16'hEA90;
    mem[16'h0042] = 16'hE301;
    mem[16'h0044] = 16'h0050;
    mem[16'h0046] = 16'hE302;
    mem[16'h0050] = 16'hFC10;
    mem[16'h0010] = 16'h0007;
    mmem = mem;
    model_reset();
    model_run(12);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", 32'(state_o), 32'h0);
    checkOutput("reset_req", 32'(mem_req_o), 32'h0);
    checkOutput("reset_we", 32'(mem_we_o), 32'h0);
    checkOutput("reset_addr", 32'(mem_addr_o), 32'h0);
    checkOutput("reset_wdata", 32'(mem_wdata_o), 32'h0);
    checkOutput("reset_A", 32'(rega_o), 32'h0);
    checkOutput("reset_D", 32'(regd_o), 32'h0);
    checkOutput("reset_PC", 32'(pc_o), 32'h0);
    checkOutput("reset_cycle_cnt", cycle_cnt_o, 32'h0);
    checkOutput("reset_retire_cnt", retire_cnt_o, 32'h0);
    resetb = 1'b1;
    @(posedge clk); #1;
    checkOutput("first_fetch_state", 32'(state_o), 32'h1);
    checkOutput("first_fetch_req", 32'(mem_req_o), 32'h1);
    checkOutput("first_fetch_we", 32'(mem_we_o), 32'h0);
    checkOutput("first_fetch_addr", 32'(mem_addr_o), 32'h0);
    applyStimulus(12, 1'b0);

    resetb    = 1'b0;
    halt_i    = 1'b0;
    check_lat = 0;
    max_wait  = 3;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    mmem = mem;
    model_reset();
    model_run(300);
    repeat (2) @(posedge clk);
    #1;
    resetb = 1'b1;
    applyStimulus(300, 1'b1);

    stall  = 1;
    halt_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("stalled_fetch_req", 32'(mem_req_o), 32'h1);
    checkOutput("stalled_fetch_state", 32'(state_o), 32'h1);
    resetb = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_req_dropped", 32'(mem_req_o), 32'h0);
    checkOutput("abort_state", 32'(state_o), 32'h0);
    checkOutput("abort_PC", 32'(pc_o), 32'h0);
    checkOutput("abort_A", 32'(rega_o), 32'h0);
    checkOutput("abort_retire_cnt", retire_cnt_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hack_core.md
# hack_core

Parametrised multi-cycle Hack CPU core. It executes standard Hack A- and C-instructions through one shared memory port with a req/ack handshake, so fetch and data memories can have any number of wait states. Data width, address width and PC stride are configurable. It sits where the fixed 16-bit datapath sits today. The memory front end (SPI bridge, on-chip RAM) attaches to the handshake port, and the debug block reads the exported A, D, PC and state.

## Interface
- `DATA_W`, default 16: width of A, D, ALU and memory data. Must be ≥16.
- `ADDR_W`, default 16: width of PC and memory address. Must be ≤DATA_W.
- `PC_STEP`, default 2: PC increment per sequential instruction.

Ports:
- `clk`, in, 1: clock.
- `resetb`, in, 1: reset, synchronous, active-low.
- `halt_i`, in, 1: request to stop at the next instruction boundary.
- `mem_req_o`, out, 1: transaction request.
- `mem_we_o`, out, 1: 1 = write, 0 = read.
- `mem_addr_o`, out, ADDR_W: transaction address.
- `mem_wdata_o`, out, DATA_W: write data.
- `mem_ack_i`, in, 1: transaction complete. Read data is valid in the same cycle.
- `mem_rdata_i`, in, DATA_W: read data.
- `rega_o`, `regd_o`, out, DATA_W: A and D registers.
- `pc_o`, out, ADDR_W: program counter.
- `state_o`, out, 3: FSM state code.
- `cycle_cnt_o`, `retire_cnt_o`, out, 32: performance counters (see Configuration).

## Operation
- Reset (`resetb` = 0 at a clk edge):
  - A, D, PC, IR and all counters are cleared to 0.
  - State becomes HALT.
  - `mem_req_o` = 0, `mem_we_o` = 0. `mem_addr_o` and `mem_wdata_o` are 0.
- States and codes: HALT = 0, FETCH = 1, DECODE = 2, READ = 3, EXEC = 4, WRITE = 5.
- HALT: no request. Go to FETCH when `halt_i` = 0.
- FETCH: request a read at PC. On ack, latch `mem_rdata_i` into IR and go to DECODE.
- DECODE: only IR[15:0] is decoded; upper bits are ignored.
  - A-instruction (IR[15] = 0): A ← zero-extended IR[14:0], PC ← PC + PC_STEP. Instruction retires. Go to FETCH, or to HALT if `halt_i` = 1.
  - C-instruction (IR[15] = 1, IR[14:13] ignored): if the a-bit IR[12] = 1, go to READ, else go to EXEC.
- READ: request a read at A[ADDR_W-1:0]. On ack, latch M and go to EXEC.
- EXEC:
  - ALU inputs: x = D, y = (a ? M : A).
  - Control bits zx, nx, zy, ny, f, no are IR[11:6], with standard Hack semantics (f = 1 selects add, f = 0 selects AND).
  - Arithmetic is modulo 2^DATA_W. Flags: zr = (out == 0), ng = out[DATA_W-1].
  - Destinations IR[5:3] = A, D, M. A and D update with the ALU result.
  - If M is a destination, latch write address = old A and write data = result.
  - Jump if (j1 & ng) | (j2 & zr) | (j3 & ~ng & ~zr), where j1, j2, j3 = IR[2:0]. Jump loads PC ← old A[ADDR_W-1:0]; otherwise PC ← PC + PC_STEP.
  - If M is a destination, go to WRITE. Otherwise the instruction retires and the FSM goes to FETCH, or HALT if `halt_i` = 1.
- WRITE: request a write with the latched address and data. On ack the instruction retires; go to FETCH, or HALT if `halt_i` = 1.
- PC and address arithmetic wrap modulo 2^ADDR_W.

## Timing
- `mem_req_o` is decoded from the registered state: it is 1 exactly in FETCH, READ and WRITE.
  - `mem_we_o` = 1 only in WRITE.
  - Address and write data are stable for the whole request.
- A transaction completes in the first cycle in which `mem_req_o` and `mem_ack_i` are both 1.
  - `mem_ack_i` is ignored while `mem_req_o` = 0.
  - Zero-wait memory acks in the first request cycle.
- Latency in cycles with zero-wait memory:
  - A-instruction: 2.
  - C-instruction without M: 3.
  - With M read: 4.
  - With M write: +1.
- `halt_i` is sampled only at retire transitions. It never aborts a request in flight or an instruction in progress.
- Reset asserted mid-transaction drops `mem_req_o` at the next edge. The memory side must tolerate the abandoned request.
- Reset has priority over all other events.

## Configuration
- `HACK_CORE_PERF_EN` defined:
  - `cycle_cnt_o` increments every cycle the state is not HALT.
  - `retire_cnt_o` increments once per retired instruction.
  - Both wrap at 2^32 and clear on reset.
- Not defined: both counter outputs are constant 0 and no counter flops are built.

## Test plan
- Reset held low 2 cycles with `halt_i` = 0, then released → state 0 for one cycle, then FETCH with req = 1, we = 0, addr = 0x0000.
- Fetch returns 0x1234 with immediate ack → next cycle is DECODE. The cycle after that: A = 0x1234, PC = 2, FETCH at addr 0x0002.
- A = 0x0010, mem[0x0010] = 0x0007, instruction 0xFDD0 (D=M+1) → READ at 0x0010, then D = 0x0008. Total 4 cycles.
- A = 0x0020, D = 5, instruction 0xE308 (M=D) → WRITE with addr = 0x0020, wdata = 0x0005, we = 1. PC = 0x0002 + previous PC.
- A = 0x0040, instruction 0xEA87 (0;JMP) → next fetch at 0x0040. With D = 0, instruction 0xE301 (D;JGT) → no jump; next fetch at PC + 2.
- Ack delayed 3 cycles with `halt_i` raised during READ → req, addr and we stay stable until ack. The instruction completes, the state goes to HALT with req = 0, and FETCH resumes after `halt_i` drops. With `HACK_CORE_PERF_EN`, `retire_cnt_o` increments by 1 and `cycle_cnt_o` stops while in HALT.
